truth_table_scorer: RTL and testbench

- Sequential fitness-evaluation stage that sits directly upstream and downstream of one evolved combinational candidate circuit (N_IN inputs, N_OUT outputs, gate-level #delays).
- Drives every input combination into the candidate and waits a programmable settle time covering gate-delay propagation.
- Samples the candidate outputs, compares them against a target truth table and accumulates a per-bit match score used as the candidate's fitness.
- One evaluation per start pulse; result held until the next start.

---
 rtl/truth_table_scorer.sv | 152 +++++++++++++++
 tb/tb_truth_table_scorer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scorer.sv
// ============================================================================
// Module   : truth_table_scorer
// Purpose  : Sweeps every input vector through a candidate circuit, samples
//            its outputs after a settle time and scores them against a target.
// Revision : 1.0
// ============================================================================
`default_nettype none

module truth_table_scorer #(
  parameter int N_IN          = 4,
  parameter int N_OUT         = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int SW            = $clog2(N_OUT * (2 ** N_IN) + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [N_OUT*(2**N_IN)-1:0]    target_table,
  input  logic [N_OUT-1:0]              dut_out,
  output logic [N_IN-1:0]               dut_in,
  output logic                          busy,
  output logic                          done,
  output logic [SW-1:0]                 score,
  output logic                          perfect,
  output logic [(2**N_IN)-1:0]          mismatch_rows
);

  localparam int              N_ROWS   = 2 ** N_IN;
  localparam int              TT_W     = N_OUT * N_ROWS;
  localparam logic [7:0]      c_reload = 8'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0]   c_max    = SW'(TT_W);
  localparam logic [SW-1:0]   c_one    = SW'(1);
  localparam logic [N_IN-1:0] c_last   = N_IN'(N_ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              r_state,   w_state;
  logic [TT_W-1:0]     r_table,   w_table;
  logic [N_IN-1:0]     r_row,     w_row;
  logic [7:0]          r_cnt,     w_cnt;
  logic [SW-1:0]       r_score,   w_score;
  logic                r_perfect, w_perfect;
  logic [N_ROWS-1:0]   r_mism,    w_mism;
  logic                r_busy,    w_busy;
  logic                r_done,    w_done;

  logic [N_OUT-1:0]    w_exp;
  logic [SW-1:0]       w_matches;
  logic [SW-1:0]       w_score_sum;
  logic                w_row_bad;

  // Case-equality so that X/Z on a candidate output never counts as a match.
  always_comb begin
    w_exp     = r_table[int'(r_row) * N_OUT +: N_OUT];
    w_matches = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (dut_out[k] === w_exp[k]) begin
        w_matches = w_matches + c_one;
      end
    end
    w_row_bad   = (dut_out !== w_exp);
    w_score_sum = r_score + w_matches;
  end

  always_comb begin
    w_state   = r_state;
    w_table   = r_table;
    w_row     = r_row;
    w_cnt     = r_cnt;
    w_score   = r_score;
    w_perfect = r_perfect;
    w_mism    = r_mism;
    w_busy    = r_busy;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_table   = target_table;
          w_score   = '0;
          w_perfect = 1'b0;
          w_mism    = '0;
          w_row     = '0;
          w_cnt     = c_reload;
          w_busy    = 1'b1;
          w_state   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt != 8'd0) begin
          w_cnt = r_cnt - 8'd1;
        end else begin
          w_score       = w_score_sum;
          w_mism[r_row] = w_row_bad;
          if (r_row == c_last) begin
            w_state   = S_DONE;
            w_busy    = 1'b0;
            w_done    = 1'b1;
            w_perfect = (w_score_sum == c_max);
          end else begin
            w_row = r_row + 1'b1;
            w_cnt = c_reload;
          end
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_table   <= '0;
      r_row     <= '0;
      r_cnt     <= '0;
      r_score   <= '0;
      r_perfect <= 1'b0;
      r_mism    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_table   <= w_table;
      r_row     <= w_row;
      r_cnt     <= w_cnt;
      r_score   <= w_score;
      r_perfect <= w_perfect;
      r_mism    <= w_mism;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  // The row counter doubles as the driven vector, so it holds all ones after DONE.
  assign dut_in        = r_row;
  assign busy          = r_busy;
  assign done          = r_done;
  assign score         = r_score;
  assign perfect       = r_perfect;
  assign mismatch_rows = r_mism;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_scorer.sv
// ============================================================================
// Module   : tb_truth_table_scorer
// Purpose  : Table-driven and randomized checks of truth_table_scorer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_truth_table_scorer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] target_table;
  logic [31:0] cand_tbl;
  logic        delayed;

  logic [1:0]  out4, out8;
  logic [3:0]  in4, in8;
  logic        busy4, busy8, done4, done8, perf4, perf8;
  logic [5:0]  score4, score8;
  logic [15:0] mism4, mism8;
  logic [1:0]  pipe4 [6];
  logic [1:0]  pipe8 [6];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  truth_table_scorer #(.N_IN(4), .N_OUT(2), .SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .target_table(target_table),
    .dut_out(out4), .dut_in(in4), .busy(busy4), .done(done4),
    .score(score4), .perfect(perf4), .mismatch_rows(mism4)
  );

  truth_table_scorer #(.N_IN(4), .N_OUT(2), .SETTLE_CYCLES(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .target_table(target_table),
    .dut_out(out8), .dut_in(in8), .busy(busy8), .done(done8),
    .score(score8), .perfect(perf8), .mismatch_rows(mism8)
  );

  // Candidate: table lookup, optionally behind a 6-clock propagation delay.
  always @(posedge clk) begin
    pipe4[0] <= cand_tbl[{in4, 1'b0} +: 2];
    pipe8[0] <= cand_tbl[{in8, 1'b0} +: 2];
    for (int i = 1; i < 6; i++) begin
      pipe4[i] <= pipe4[i-1];
      pipe8[i] <= pipe8[i-1];
    end
  end

  always_comb begin
    out4 = delayed ? pipe4[5] : cand_tbl[{in4, 1'b0} +: 2];
    out8 = delayed ? pipe8[5] : cand_tbl[{in8, 1'b0} +: 2];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy4 || busy8 || done4 || done8) && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    check("idle_wait_timeout", 32'(guard < 500), 32'd1);
  endtask

  task automatic run_eval(input bit sel8, input logic [31:0] tgt, input logic [31:0] cand,
                          input bit dly, input bit restarts,
                          output logic [5:0] s, output logic [15:0] m, output logic p);
    int cyc = 0;
    int lat;
    int extra = 0;
    bit busy_drop = 0;
    lat = sel8 ? 128 : 64;
    wait_idle();
    target_table = tgt;
    cand_tbl     = cand;
    delayed      = dly;
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    target_table = ~tgt;
    while (cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start = restarts && (cyc == 9 || cyc == 63);
      if (sel8 ? done8 : done4) break;
      if (!(sel8 ? busy8 : busy4)) busy_drop = 1;
    end
    start = 1'b0;
    check("done_latency", cyc, lat);
    check("busy_held", 32'(busy_drop), 32'd0);
    check("busy_low_at_done", 32'(sel8 ? busy8 : busy4), 32'd0);
    s = sel8 ? score8 : score4;
    m = sel8 ? mism8 : mism4;
    p = sel8 ? perf8 : perf4;
    @(posedge clk); #1;
    check("done_one_cycle", 32'(sel8 ? done8 : done4), 32'd0);
    check("dut_in_hold", 32'(sel8 ? in8 : in4), 32'hF);
    if (restarts) begin
      repeat (80) begin
        @(posedge clk); #1;
        if (sel8 ? done8 : done4) extra++;
      end
      check("restart_extra_done", extra, 0);
      check("restart_score_hold", 32'(sel8 ? score8 : score4), 32'(s));
    end
  endtask

  typedef struct {
    bit          sel8;
    bit          dly;
    bit          restart;
    bit          exact;
    logic [31:0] tgt;
    logic [31:0] cand;
    logic [5:0]  exp_score;
    logic [15:0] exp_mism;
    logic        exp_perf;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [31:0] loop_tbl;
    logic [31:0] diff;
    logic [5:0]  s, es;
    logic [15:0] m, em;
    logic        p;
    int          sel;

    loop_tbl = '0;
    for (int r = 0; r < 16; r++) begin
      loop_tbl[2*r]   = r[0];
      loop_tbl[2*r+1] = ~r[1];
    end

    vecs[0] = '{sel8:0, dly:0, restart:0, exact:1, tgt:32'hA5C3_0F96, cand:32'hA5C3_0F96,
                exp_score:6'd32, exp_mism:16'h0000, exp_perf:1'b1};
    vecs[1] = '{sel8:0, dly:0, restart:0, exact:1, tgt:32'hFFFF_FFFF, cand:32'h0,
                exp_score:6'd0, exp_mism:16'hFFFF, exp_perf:1'b0};
    vecs[2] = '{sel8:0, dly:0, restart:0, exact:1, tgt:loop_tbl ^ 32'h0000_0400, cand:loop_tbl,
                exp_score:6'd31, exp_mism:16'h0020, exp_perf:1'b0};
    vecs[3] = '{sel8:0, dly:1, restart:0, exact:0, tgt:32'hA5C3_0F96, cand:32'hA5C3_0F96,
                exp_score:6'd0, exp_mism:16'h0000, exp_perf:1'b0};
    vecs[4] = '{sel8:1, dly:1, restart:0, exact:1, tgt:32'hA5C3_0F96, cand:32'hA5C3_0F96,
                exp_score:6'd32, exp_mism:16'h0000, exp_perf:1'b1};
    vecs[5] = '{sel8:0, dly:0, restart:1, exact:1, tgt:32'hA5C3_0F96, cand:32'hA5C3_0F96 ^ 32'h0000_8001,
                exp_score:6'd30, exp_mism:16'h0081, exp_perf:1'b0};
    vecs[6] = '{sel8:0, dly:0, restart:0, exact:1, tgt:32'h0, cand:32'h0,
                exp_score:6'd32, exp_mism:16'h0000, exp_perf:1'b1};

    rst = 1'b1; start = 1'b0; target_table = '0; cand_tbl = '0; delayed = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_busy",  32'(busy4),  32'd0);
    check("reset_done",  32'(done4),  32'd0);
    check("reset_score", 32'(score4), 32'd0);
    check("reset_perf",  32'(perf4),  32'd0);
    check("reset_mism",  32'(mism4),  32'd0);
    check("reset_dutin", 32'(in4),    32'd0);

    for (int v = 0; v < 7; v++) begin
      run_eval(vecs[v].sel8, vecs[v].tgt, vecs[v].cand, vecs[v].dly, vecs[v].restart, s, m, p);
      if (vecs[v].exact) begin
        check($sformatf("vec%0d_score", v), 32'(s), 32'(vecs[v].exp_score));
        check($sformatf("vec%0d_mism", v),  32'(m), 32'(vecs[v].exp_mism));
        check($sformatf("vec%0d_perf", v),  32'(p), 32'(vecs[v].exp_perf));
      end else begin
        check($sformatf("vec%0d_mism_nonzero", v), 32'(m != 16'h0), 32'd1);
        check($sformatf("vec%0d_perf", v), 32'(p), 32'd0);
      end
    end

    // Reset in the middle of an evaluation.
    wait_idle();
    target_table = 32'hA5C3_0F96; cand_tbl = 32'hA5C3_0F96; delayed = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_busy",  32'(busy4),  32'd0);
    check("midrst_dutin", 32'(in4),    32'd0);
    check("midrst_score", 32'(score4), 32'd0);
    check("midrst_mism",  32'(mism4),  32'd0);
    begin
      int dn = 0;
      repeat (80) begin
        @(posedge clk); #1;
        if (done4) dn++;
      end
      check("midrst_no_done", dn, 0);
    end
    run_eval(0, 32'hA5C3_0F96, 32'hA5C3_0F96, 0, 0, s, m, p);
    check("postrst_score", 32'(s), 32'd32);
    check("postrst_perf",  32'(p), 32'd1);

    // Randomized tables against an arithmetic scoring model.
    for (int t = 0; t < 16; t++) begin
      logic [31:0] tg, cd;
      tg  = $urandom;
      sel = $urandom_range(0, 2);
      case (sel)
        0:       cd = tg;
        1:       cd = tg ^ (32'd1 << $urandom_range(0, 31));
        default: cd = $urandom;
      endcase
      diff = tg ^ cd;
      es   = 6'(32 - $countones(diff));
      for (int r = 0; r < 16; r++) em[r] = |diff[2*r +: 2];
      run_eval(0, tg, cd, 0, 0, s, m, p);
      check($sformatf("rand%0d_score", t), 32'(s), 32'(es));
      check($sformatf("rand%0d_mism", t),  32'(m), 32'(em));
      check($sformatf("rand%0d_perf", t),  32'(p), 32'(es == 6'd32));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
